i2c_target_rx: RTL

- I2C target (slave) receiver; the bus-side counterpart of the team's I2C initiator write path.
- Oversamples SCL/SDA on sys_clk, detects START/STOP, and matches a 7-bit address.
- Acknowledges write transfers by pulling SDA low, then delivers each received data byte on a valid/ready handshake.
- Sits behind the open-drain pad cells; used as the control-register port of the audio block.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_target_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the initiator and the target side.
// Holds the receive FSM state encoding and the R/W bit meaning.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the system clock domain and derives edge and
// START/STOP condition pulses from the synchronized levels.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  // Idle bus level is high, so everything resets to 1 to avoid false edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_o      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_o & ~scl_hist_q;
  assign scl_fall_o = ~scl_o & scl_hist_q;
  assign start_o    = sda_hist_q & ~sda_o & scl_o;
  assign stop_o     = ~sda_hist_q & sda_o & scl_o;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver: matches a 7-bit write address, ACKs each byte it can
// store and hands received bytes to a valid/ready consumer.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       bus_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       rx_overrun,
  output logic       start_det
);
  import i2c_pkg::*;

  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_o     (scl_s),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_cond),
    .stop_o    (stop_cond)
  );

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       ack_drv_q;
  logic       first_q;
  logic       sda_oe_q, bus_busy_q, rx_valid_q, rx_first_q, rx_overrun_q, start_det_q;
  logic [7:0] rx_data_q;
  logic [7:0] byte_w;
  logic       free_slot;

  assign byte_w    = {shift_q, sda_s};
  // A consumer accepting in this very cycle frees the slot for the new byte.
  assign free_slot = !rx_valid_q || rx_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      ack_drv_q    <= 1'b0;
      first_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      bus_busy_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_first_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      start_det_q  <= 1'b0;
    end else begin
      start_det_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (start_cond) begin
        state_q     <= ST_ADDR;
        bit_cnt_q   <= 3'd0;
        sda_oe_q    <= 1'b0;
        ack_drv_q   <= 1'b0;
        start_det_q <= 1'b1;
        bus_busy_q  <= 1'b1;
      end else if (stop_cond) begin
        state_q    <= ST_IDLE;
        sda_oe_q   <= 1'b0;
        ack_drv_q  <= 1'b0;
        bus_busy_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= byte_w[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (byte_w[7:1] == ADDR && byte_w[0] == I2C_RW_WRITE) state_q <= ST_ADDR_ACK;
                else                                                 state_q <= ST_IGNORE;
              end
            end
          end
          // First SCL fall opens the ACK bit, the second one closes it.
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                sda_oe_q  <= 1'b1;
                ack_drv_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                ack_drv_q <= 1'b0;
                if (state_q == ST_ADDR_ACK) first_q <= 1'b1;
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (scl_rise) begin
              shift_q   <= byte_w[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (free_slot) begin
                  rx_data_q  <= byte_w;
                  rx_first_q <= first_q;
                  first_q    <= 1'b0;
                  rx_valid_q <= 1'b1;
                  state_q    <= ST_DATA_ACK;
                end else begin
                  rx_overrun_q <= 1'b1;
                  state_q      <= ST_IGNORE;
                end
              end
            end
          end
          ST_IGNORE: begin
            if (!scl_s) sda_oe_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe     = sda_oe_q;
  assign bus_busy   = bus_busy_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_first   = rx_first_q;
  assign rx_overrun = rx_overrun_q;
  assign start_det  = start_det_q;

endmodule
